// File: rtl/sobel_pkg.sv
// Shared constants, state encoding and latency helper for the Sobel frame engine.
package sobel_pkg;

    localparam int unsigned H_RES_DEF   = 640;
    localparam int unsigned V_RES_DEF   = 480;
    localparam int unsigned PIX_W_DEF   = 4;
    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned GRAD_W      = 8;
    localparam int unsigned FRAME_PIX   = H_RES_DEF * V_RES_DEF;
    localparam int unsigned PIPE_STAGES = 4;

    // Read-to-write distance: one line plus one pixel of window lag, plus the pipeline.
    function automatic int unsigned sobel_latency(input int unsigned h_res);
        return h_res + 1 + PIPE_STAGES;
    endfunction

    localparam int unsigned LATENCY = sobel_latency(H_RES_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } sobel_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Fixed-length delay line: dout is the din sample presented DEPTH cycles earlier.
module sobel_line_buffer
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 4
) (
    input  logic             GCLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // Oldest entry sits at the write pointer, so read-before-overwrite gives a DEPTH delay.
    assign dout = mem[ptr];

    // Storage write: contents are never cleared, only overwritten.
    always_ff @(posedge GCLK) begin
        mem[ptr] <= din;
    end

    // Circular pointer advancing every cycle.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (ptr == PTR_LAST) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/sobel_frame_engine.sv
// Streams one frame from the static store through a 3x3 Sobel operator into the edge store.
module sobel_frame_engine
    import sobel_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF,
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic              GCLK,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned FRAME = H_RES * V_RES;
    localparam int unsigned LAT   = sobel_latency(H_RES);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned XW    = $clog2(H_RES);
    localparam int unsigned YW    = $clog2(V_RES + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME - 1);
    localparam logic [CNT_W-1:0]  EMIT_FIRST = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0]  EMIT_STOP  = CNT_W'(LAT - 1 + FRAME);
    localparam logic [XW-1:0]     X_LAST     = XW'(H_RES - 1);
    localparam logic [YW-1:0]     Y_LAST     = YW'(V_RES - 1);
    localparam logic [GRAD_W-1:0] PIX_MAX    = GRAD_W'((1 << PIX_W) - 1);

    sobel_state_t             state, state_nx;
    logic                     start_q, start_rise;
    logic                     pass_active, emit, border;
    logic [CNT_W-1:0]         cnt;
    logic [XW-1:0]            ox;
    logic [YW-1:0]            oy;
    logic [PIX_W-1:0]         lb0_out, lb1_out;
    logic [PIX_W-1:0]         win [3][3];
    logic signed [GRAD_W-1:0] gx, gy, gx_nx, gy_nx;
    logic [GRAD_W-1:0]        gx_abs, gy_abs, mag, mag_q;
    logic [PIX_W-1:0]         pix_nx;

    function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed(GRAD_W'(p));
    endfunction

    assign start_rise  = start & ~start_q;
    assign pass_active = (state == ST_RUN) || (state == ST_FLUSH);
    // Output j is finalised LAT-1 cycles after its read address; the write lands one cycle later.
    assign emit        = pass_active && (cnt >= EMIT_FIRST) && (cnt < EMIT_STOP);

    sobel_line_buffer #(.DEPTH(H_RES), .WIDTH(PIX_W)) u_lb0 (
        .GCLK  (GCLK),
        .reset (reset),
        .din   (rd_data),
        .dout  (lb0_out)
    );

    sobel_line_buffer #(.DEPTH(H_RES), .WIDTH(PIX_W)) u_lb1 (
        .GCLK  (GCLK),
        .reset (reset),
        .din   (lb0_out),
        .dout  (lb1_out)
    );

    // State register and start edge detector (preset high so a held start is ignored).
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            start_q <= 1'b1;
        end else begin
            state   <= state_nx;
            start_q <= start;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_rise) state_nx = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (rd_addr == LAST_ADDR) state_nx = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (wr_en && (wr_addr == LAST_ADDR)) state_nx = ST_DONE;
            end
            ST_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read address sweep and pass cycle counter.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            cnt     <= '0;
        end else if (!pass_active) begin
            rd_addr <= '0;
            cnt     <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if ((state == ST_RUN) && (rd_addr != LAST_ADDR)) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
        end
    end

    // 3x3 window shift (right column fed from both line buffers and the live pixel) and gradient stage.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            gx <= '0;
            gy <= '0;
        end else begin
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_out;
            win[1][2] <= lb0_out;
            win[2][2] <= rd_data;
            gx        <= gx_nx;
            gy        <= gy_nx;
        end
    end

    // Sobel kernels with 1,2,1 weights: right minus left, bottom minus top.
    always_comb begin
        gx_nx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy_nx = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
    end

    // Magnitude, scale, saturate; border pixels are zeroed so wrapped neighbours never leak out.
    always_comb begin
        gx_abs = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
        gy_abs = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
        mag    = gx_abs + gy_abs;
        mag_q  = mag >> 2;
        border = (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);
        pix_nx = (mag_q > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : mag_q[PIX_W-1:0];
        if (border) pix_nx = '0;
    end

    // Write port and output raster position.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            ox      <= '0;
            oy      <= '0;
        end else begin
            wr_en <= emit;
            if (emit) begin
                wr_addr <= ADDR_W'(cnt - EMIT_FIRST);
                wr_data <= pix_nx;
                if (ox == X_LAST) begin
                    ox <= '0;
                    oy <= oy + YW'(1);
                end else begin
                    ox <= ox + XW'(1);
                end
            end else if (!pass_active) begin
                ox <= '0;
                oy <= '0;
            end
        end
    end

endmodule

// File: doc/sobel_frame_engine.md
SOBEL_FRAME_ENGINE -- requirements
Module: sobel_frame_engine

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter PIX_W, default 4, meaning grayscale pixel width.
REQ-004 SHALL have port GCLK, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1; a rising edge requests one frame pass once the static frame store is stable.
REQ-007 SHALL have port rd_addr, output, 19, static frame store read address, raster order y*H_RES+x.
REQ-008 SHALL have port rd_data, input, PIX_W, static frame store read data, valid 1 cycle after rd_addr.
REQ-009 SHALL have port wr_en, output, 1, edge frame store write enable.
REQ-010 SHALL have port wr_addr, output, 19, edge frame store write address.
REQ-011 SHALL have port wr_data, output, PIX_W, edge magnitude.
REQ-012 SHALL have port busy, output, 1, high from RUN entry through DONE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the final write.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-015 SHALL leave IDLE only on a start rising edge (registered start vs current start); start held high SHALL NOT retrigger.
REQ-016 SHALL ignore start in RUN, FLUSH, and DONE.
REQ-017 In RUN, SHALL present rd_addr 0..H_RES*V_RES-1, one address per cycle with no gaps, then enter FLUSH.
REQ-018 In FLUSH, SHALL hold rd_addr at H_RES*V_RES-1, treat rd_data as don't-care, and run until the last write.
REQ-019 SHALL form a 3x3 window from two line buffers of H_RES x PIX_W plus a 3x3 register window.
REQ-020 SHALL compute Gx = (right column) - (left column) and Gy = (bottom row) - (top row), with weights 1,2,1; SHALL use signed 8-bit arithmetic (range -60..60).
REQ-021 SHALL compute mag = |Gx|+|Gy| as unsigned 8 bits and wr_data = min(mag>>2, 2^PIX_W-1).
REQ-022 SHALL force wr_data = 0 for x=0, x=H_RES-1, y=0, y=V_RES-1, without ever using pixels wrapped from adjacent lines or frames.
REQ-023 SHALL write every output index 0..H_RES*V_RES-1 exactly once, in ascending order, on consecutive cycles.
REQ-024 SHALL assert wr_en with wr_addr=i exactly 645 cycles after the cycle rd_addr=i is presented, i.e. 641-pixel window lag plus 4 pipeline stages.
REQ-025 SHALL pulse done for exactly one cycle, in DONE, on the cycle after the write of index H_RES*V_RES-1, then return to IDLE.
REQ-026 SHALL hold wr_en=0 at all times outside the 307200 write cycles.

Reset
REQ-027 On reset, SHALL set the state to IDLE, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, and the start edge register to 1 so a start already high does not trigger.
REQ-028 SHALL abort on reset mid-pass, with wr_en low asynchronously; line buffer contents need not be cleared.

Structure
REQ-029 SHALL take H_RES/V_RES defaults, FRAME_PIX=307200, ADDR_W=19, PIX_W, the LATENCY=645 constant, and the state enum from shared package sobel_pkg.
REQ-030 SHALL implement line storage as one sub-module, sobel_line_buffer (depth H_RES, 1-cycle delay-line semantics), instantiated twice.

Verification
REQ-031 Uniform frame (all 9), start pulse -> 307200 writes, all wr_data=0, single done pulse 307200+645+1 cycles after start edge.
REQ-032 Vertical step (x<320: 0, x>=320: 15) -> wr_data=15 at x=319 and x=320 for y=1..478; 0 elsewhere, including borders.
REQ-033 Horizontal step (y<240: 0, y>=240: 15) -> wr_data=15 at y=239 and y=240 for x=1..638; 0 elsewhere.
REQ-034 Latency/order -> every wr_addr=i occurs exactly 645 cycles after rd_addr=i; no gaps; no duplicates.
REQ-035 Start held high after done, plus extra start pulses mid-RUN -> exactly one pass, one done.
REQ-036 Reset asserted at write index 1000, then released and started -> wr_en drops immediately; a clean full pass follows with correct data.
